// File: rtl/secuenciador_defs.sv
// ---------------------------------------------------------------------------
// secuenciador_defs
//
// Definitions shared by the power-up sequencer and its interval timer:
//   - estado_t   : 3-bit encoding of the sequencer states.
//   - cnt_width  : width of the interval counter, sized to hold the larger of
//                  the HOLD and TIMEOUT intervals without wrapping.
// ---------------------------------------------------------------------------
package secuenciador_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READY = 3'd3,
        ST_FAULT = 3'd4
    } estado_t;

    // $clog2(max(hold, timeout) + 1)
    function automatic int cnt_width(input int hold, input int timeout);
        int mayor;
        mayor = (hold > timeout) ? hold : timeout;
        return $clog2(mayor + 1);
    endfunction

endpackage

// File: rtl/temporizador.sv
// ---------------------------------------------------------------------------
// temporizador
//
// Clearable up-counter with a terminal-count compare. The sequencer uses one
// instance for both the reset-hold interval and the acknowledge timeout by
// switching the compare value with its state.
//
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, clears the count
//   clr_i      : synchronous clear (has priority over en_i)
//   en_i       : count enable
//   limite_i   : terminal-count value compared against the current count
//   fin_o      : high while the current count equals limite_i
// ---------------------------------------------------------------------------
module temporizador #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limite_i,
    output logic         fin_o
);

    logic [W-1:0] cuenta_q;

    // The count saturates instead of wrapping; in normal use it is cleared
    // on reaching the terminal count, so saturation is only a safety net.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cuenta_q <= '0;
        end else if (en_i && (cuenta_q != '1)) begin
            cuenta_q <= cuenta_q + 1'b1;
        end
    end

    assign fin_o = (cuenta_q == limite_i);

endmodule

// File: rtl/secuenciador_arranque.sv
// ---------------------------------------------------------------------------
// secuenciador_arranque
//
// Power-up sequencer. After `ini` is seen it releases the resets of N
// subsystems one at a time in index order: each stage is held in reset for
// HOLD cycles, released, and then the sequencer waits up to TIMEOUT cycles
// for that stage's `done` acknowledge before moving on. When the last stage
// acknowledges, `ready` rises. A missed acknowledge latches `fault`, puts
// every subsystem back into reset and stays there until `rst`.
//
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset (priority over everything)
//   ini        : level start request from the power-on initializer
//   done[N]    : per-stage acknowledge, only done[stage] is looked at, and
//                only while waiting
//   rst_stage  : active-high reset per subsystem (registered)
//   stage      : index of the current / last stage (registered)
//   ready      : all stages released and acknowledged (registered)
//   fault      : sticky acknowledge-timeout flag (registered)
//   estado_o   : current FSM state, for observation only
// ---------------------------------------------------------------------------
module secuenciador_arranque
    import secuenciador_defs::*;
#(
    parameter int N       = 4,
    parameter int HOLD    = 16,
    parameter int TIMEOUT = 1024,
    localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ini,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  rst_stage,
    output logic [SW-1:0] stage,
    output logic          ready,
    output logic          fault,
    output estado_t       estado_o
);

    localparam int            CW       = cnt_width(HOLD, TIMEOUT);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD - 1);
    localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] LAST     = SW'(N - 1);

    estado_t       state_q;
    logic [N-1:0]  rst_stage_q;
    logic [SW-1:0] stage_q;
    logic          ready_q;
    logic          fault_q;

    // Timer control, derived from the registered state.
    logic          t_clr;
    logic          t_en;
    logic [CW-1:0] t_limite;
    logic          t_fin;
    logic          done_k;

    // Only the acknowledge of the stage currently being sequenced matters.
    assign done_k = done[stage_q];

    // The counter is cleared on every state change and whenever it is not
    // actively timing an interval, so each HOLD and WAIT starts from zero.
    always_comb begin
        t_clr    = 1'b1;
        t_en     = 1'b0;
        t_limite = TO_LIM;
        case (state_q)
            ST_HOLD: begin
                t_limite = HOLD_LIM;
                if (!t_fin) begin
                    t_clr = 1'b0;
                    t_en  = 1'b1;
                end
            end
            ST_WAIT: begin
                // Acknowledge or timeout both leave WAIT: clear in either case.
                if (!done_k && !t_fin) begin
                    t_clr = 1'b0;
                    t_en  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    temporizador #(
        .W (CW)
    ) u_temporizador (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (t_clr),
        .en_i     (t_en),
        .limite_i (t_limite),
        .fin_o    (t_fin)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rst_stage_q <= '1;
            stage_q     <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ini) begin
                        state_q <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    // Release only the current stage; lower stages are
                    // already out of reset, higher ones stay held.
                    if (t_fin) begin
                        rst_stage_q[stage_q] <= 1'b0;
                        state_q              <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // An acknowledge on the final timeout edge still counts.
                    if (done_k) begin
                        if (stage_q == LAST) begin
                            ready_q <= 1'b1;
                            state_q <= ST_READY;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                            state_q <= ST_HOLD;
                        end
                    end else if (t_fin) begin
                        fault_q     <= 1'b1;
                        rst_stage_q <= '1;
                        state_q     <= ST_FAULT;
                    end
                end

                ST_READY: begin
                    if (!ini) begin
                        rst_stage_q <= '1;
                        ready_q     <= 1'b0;
                        stage_q     <= '0;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_FAULT: begin
                    // Terminal until rst; stage keeps the failing index.
                    fault_q     <= 1'b1;
                    ready_q     <= 1'b0;
                    rst_stage_q <= '1;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    rst_stage_q <= '1;
                    stage_q     <= '0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rst_stage = rst_stage_q;
    assign stage     = stage_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign estado_o  = state_q;

endmodule

// File: tb/tb_secuenciador_arranque.sv
// ---------------------------------------------------------------------------
// tb_secuenciador_arranque
//
// Bench for the power-up sequencer with N=4, HOLD=4, TIMEOUT=16.
// A timing-based reference model (stage index, cycles elapsed in the current
// stage, number of stages released) predicts every output each cycle; a
// table of held-input segments and a few hand sequences add fixed expected
// values at the points of interest.
// ---------------------------------------------------------------------------
module tb_secuenciador_arranque;
    import secuenciador_defs::*;

    localparam int N       = 4;
    localparam int HOLD    = 4;
    localparam int TIMEOUT = 16;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ini = 1'b0;
    logic [N-1:0] done = '0;
    logic [N-1:0] rst_stage;
    logic [1:0]   stage;
    logic         ready;
    logic         fault;
    estado_t      estado;

    always #5 clk = ~clk;

    secuenciador_arranque #(
        .N       (N),
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ini       (ini),
        .done      (done),
        .rst_stage (rst_stage),
        .stage     (stage),
        .ready     (ready),
        .fault     (fault),
        .estado_o  (estado)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Described in terms of time: m_t counts edges since the current stage
    // started holding; the first HOLD edges are the hold, later ones waiting.
    bit m_started  = 0;
    int m_k        = 0;
    int m_t        = 0;
    int m_released = 0;
    bit m_ready    = 0;
    bit m_fault    = 0;

    task automatic model_step(input logic r, input logic i, input logic [N-1:0] d);
        if (r) begin
            m_started = 0; m_k = 0; m_t = 0; m_released = 0;
            m_ready = 0; m_fault = 0;
        end else if (m_fault) begin
            // stuck until reset
        end else if (m_ready) begin
            if (!i) begin
                m_started = 0; m_k = 0; m_t = 0; m_released = 0; m_ready = 0;
            end
        end else if (!m_started) begin
            if (i) begin
                m_started = 1; m_t = 0;
            end
        end else if (m_t < HOLD) begin
            m_t++;
            if (m_t == HOLD) m_released = m_k + 1;
        end else begin
            if (d[m_k]) begin
                if (m_k == N - 1) m_ready = 1;
                else begin
                    m_k++; m_t = 0;
                end
            end else if (m_t - HOLD == TIMEOUT - 1) begin
                m_fault = 1;
            end else begin
                m_t++;
            end
        end
    endtask

    function automatic logic [10:0] model_outs();
        logic [N-1:0] rel_mask;
        logic [N-1:0] rs;
        logic [2:0]   st;
        rel_mask = N'((1 << m_released) - 1);
        rs = m_fault ? '1 : ~rel_mask;
        if (m_fault)         st = 3'(ST_FAULT);
        else if (m_ready)    st = 3'(ST_READY);
        else if (!m_started) st = 3'(ST_IDLE);
        else if (m_t < HOLD) st = 3'(ST_HOLD);
        else                 st = 3'(ST_WAIT);
        return {st, m_fault, m_ready & ~m_fault, 2'(m_k), rs};
    endfunction

    function automatic logic [10:0] dut_outs();
        return {3'(estado), fault, ready, stage, rst_stage};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive on the falling edge, advance DUT and model on the
    // rising edge, compare shortly after.
    task automatic step(input logic r, input logic i, input logic [N-1:0] d);
        @(negedge clk);
        rst  = r;
        ini  = i;
        done = d;
        @(posedge clk);
        model_step(r, i, d);
        #1;
        check("model", 32'(dut_outs()), 32'(model_outs()));
    endtask

    task automatic run(input logic r, input logic i, input logic [N-1:0] d, input int n);
        for (int c = 0; c < n; c++) step(r, i, d);
    endtask

    task automatic expect_outs(input string name, input logic [3:0] e_rs, input logic [1:0] e_st,
                               input logic e_rdy, input logic e_flt);
        check(name, {20'd0, rst_stage, stage, ready, fault, 4'd0},
                    {20'd0, e_rs, e_st, e_rdy, e_flt, 4'd0});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r;
        logic       i;
        logic [3:0] d;
        int         n;
        logic [3:0] e_rs;
        logic [1:0] e_st;
        logic       e_rdy;
        logic       e_flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic i, input logic [3:0] d, input int n,
                                input logic [3:0] e_rs, input logic [1:0] e_st,
                                input logic e_rdy, input logic e_flt);
        vec_t v;
        v.r = r; v.i = i; v.d = d; v.n = n;
        v.e_rs = e_rs; v.e_st = e_st; v.e_rdy = e_rdy; v.e_flt = e_flt;
        return v;
    endfunction

    initial begin
        // Nominal sequence; each row holds its inputs for n edges and is
        // checked after the last one.
        tbl.push_back(mk(1, 0, 4'h0,   2, 4'hF, 2'd0, 0, 0)); // reset state
        tbl.push_back(mk(0, 1, 4'h0,   4, 4'hF, 2'd0, 0, 0)); // start + 3 hold edges
        tbl.push_back(mk(0, 1, 4'h0,   1, 4'hE, 2'd0, 0, 0)); // stage 0 released
        tbl.push_back(mk(0, 1, 4'h0,   2, 4'hE, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 4'h1,   1, 4'hE, 2'd1, 0, 0)); // ack 0
        tbl.push_back(mk(0, 1, 4'h1,   4, 4'hC, 2'd1, 0, 0)); // stage 1 released
        tbl.push_back(mk(0, 1, 4'h0,   2, 4'hC, 2'd1, 0, 0));
        tbl.push_back(mk(0, 1, 4'h2,   1, 4'hC, 2'd2, 0, 0)); // ack 1
        tbl.push_back(mk(0, 1, 4'h0,   4, 4'h8, 2'd2, 0, 0)); // stage 2 released
        tbl.push_back(mk(0, 1, 4'h0,   2, 4'h8, 2'd2, 0, 0));
        tbl.push_back(mk(0, 1, 4'h4,   1, 4'h8, 2'd3, 0, 0)); // ack 2
        tbl.push_back(mk(0, 1, 4'h0,   4, 4'h0, 2'd3, 0, 0)); // stage 3 released
        tbl.push_back(mk(0, 1, 4'h0,   2, 4'h0, 2'd3, 0, 0));
        tbl.push_back(mk(0, 1, 4'h8,   1, 4'h0, 2'd3, 1, 0)); // ack 3 -> ready
        tbl.push_back(mk(0, 1, 4'h0,   5, 4'h0, 2'd3, 1, 0)); // ready holds
        tbl.push_back(mk(0, 0, 4'h0,   1, 4'hF, 2'd0, 0, 0)); // ini drop from ready
        tbl.push_back(mk(0, 0, 4'hF, 100, 4'hF, 2'd0, 0, 0)); // start gating

        for (int v = 0; v < tbl.size(); v++) begin
            run(tbl[v].r, tbl[v].i, tbl[v].d, tbl[v].n);
            expect_outs($sformatf("vec%0d", v), tbl[v].e_rs, tbl[v].e_st, tbl[v].e_rdy, tbl[v].e_flt);
        end
        check("idle_state", 32'(estado), 32'(ST_IDLE));

        // Re-raise ini with every done already high: best case, 21 edges.
        run(0, 1, 4'hF, 20);
        expect_outs("best_case_minus1", 4'h0, 2'd3, 0, 0);
        run(0, 1, 4'hF, 1);
        expect_outs("best_case_ready", 4'h0, 2'd3, 1, 0);

        // Foreign done ignored, then done on the very last timeout edge.
        run(1, 0, 4'h0, 2);
        run(0, 1, 4'h0, 5);
        run(0, 1, 4'h8, 10);
        expect_outs("foreign_done", 4'hE, 2'd0, 0, 0);
        run(0, 1, 4'h1, 1);
        run(0, 1, 4'h0, 4);
        run(0, 1, 4'h0, 15);
        expect_outs("wait15", 4'hC, 2'd1, 0, 0);
        run(0, 1, 4'h2, 1);
        expect_outs("done_beats_timeout", 4'hC, 2'd2, 0, 0);

        // Timeout on stage 1.
        run(1, 0, 4'h0, 2);
        run(0, 1, 4'h0, 5);
        run(0, 1, 4'h1, 1);
        run(0, 1, 4'h0, 4);
        run(0, 1, 4'h0, 15);
        expect_outs("pre_timeout", 4'hC, 2'd1, 0, 0);
        run(0, 1, 4'h0, 1);
        expect_outs("timeout", 4'hF, 2'd1, 0, 1);
        run(0, 0, 4'hF, 20);
        expect_outs("fault_sticky", 4'hF, 2'd1, 0, 1);
        run(1, 1, 4'h0, 1);
        expect_outs("fault_cleared", 4'hF, 2'd0, 0, 0);

        // Reset during stage 2 WAIT with ini held, then restart.
        run(0, 1, 4'h0, 5);
        run(0, 1, 4'h1, 1);
        run(0, 1, 4'h0, 4);
        run(0, 1, 4'h2, 1);
        run(0, 1, 4'h0, 4);
        run(0, 1, 4'h0, 3);
        expect_outs("stage2_wait", 4'h8, 2'd2, 0, 0);
        run(1, 1, 4'h0, 1);
        expect_outs("mid_reset", 4'hF, 2'd0, 0, 0);
        run(0, 1, 4'h0, 5);
        expect_outs("restart", 4'hE, 2'd0, 0, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic         r;
            logic         i;
            logic [N-1:0] d;
            r = ($urandom_range(0, 299) == 0);
            i = ($urandom_range(0, 29) != 0);
            for (int b = 0; b < N; b++) d[b] = ($urandom_range(0, 5) == 0);
            step(r, i, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
